// File: rtl/sparse_frame_loader_pkg.sv
// sparse_pkg: shared constants, parser states and FIFO entry layout for the sparse frame loader
package sparse_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam int ENTRY_IDX_W = 10;
  typedef enum logic [2:0] {IDLE, HDR, IDX_HI, IDX_LO, VAL_HI, VAL_LO, CSUM} loader_state_t;
  typedef struct packed {
    logic vec;
    logic [ENTRY_IDX_W-1:0] index;
    logic [15:0] value;
    logic last;
  } entry_t;
endpackage

// File: rtl/sparse_frame_loader_if.sv
// sparse_frame_loader_if: rx byte stream, entry stream, status pulses and tx handshake
interface sparse_frame_loader_if #(parameter int IDX_W = 10);
  logic [7:0] rx_data;
  logic rx_valid;
  logic entry_valid, entry_ready, entry_vec, entry_last;
  logic [IDX_W-1:0] entry_index;
  logic [15:0] entry_value;
  logic frame_ok, frame_error;
  logic [7:0] tx_data;
  logic tx_start, tx_busy;
  modport master (input rx_data, rx_valid, entry_ready, tx_busy,
                  output entry_valid, entry_vec, entry_index, entry_value, entry_last,
                  frame_ok, frame_error, tx_data, tx_start);
  modport slave (output rx_data, rx_valid, entry_ready, tx_busy,
                 input entry_valid, entry_vec, entry_index, entry_value, entry_last,
                 frame_ok, frame_error, tx_data, tx_start);
endinterface

// File: rtl/sparse_frame_loader_fifo.sv
// sparse_entry_fifo: first-word-fall-through FIFO of entry_t with full/empty flags
module sparse_entry_fifo import sparse_pkg::*; #(parameter int FIFO_DEPTH = 8) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  entry_t mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign rd = pop & !empty;
  assign wr = push & (!full | rd);
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign head = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + {{AW{1'b0}}, 1'b1};
      end
      if (rd) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/sparse_frame_loader.sv
// sparse_frame_loader: deframes UART bytes into sparse entries, buffers them and answers ACK/NAK
module sparse_frame_loader import sparse_pkg::*; #(
  parameter int IDX_W = ENTRY_IDX_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic clk,
  input logic reset,
  sparse_frame_loader_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  loader_state_t state, state_n;
  logic [7:0] csum, idx_hi, val_hi, resp;
  logic [6:0] count;
  logic [IDX_W-1:0] cur, prev;
  logic [15:0] idx_w;
  logic [TW-1:0] tcnt;
  logic vec, first, push_q, ok_q, err_q, pend, ok_n, err_n;
  logic full, empty, pop, drop, timeout;
  entry_t push_d, head;
  sparse_entry_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .reset(reset), .push(push_q), .pop(bus.entry_ready),
    .din(push_d), .head(head), .full(full), .empty(empty)
  );
  assign pop = bus.entry_ready & !empty;
  // a registered push that finds the FIFO full (and not draining) kills the frame in that cycle
  assign drop = push_q & full & !pop;
  assign timeout = state != IDLE && !bus.rx_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign idx_w = {idx_hi, bus.rx_data};
  always_comb begin
    state_n = state;
    ok_n = 1'b0;
    err_n = 1'b0;
    if (drop) state_n = IDLE;
    else if (timeout) begin
      err_n = 1'b1;
      state_n = IDLE;
    end else if (bus.rx_valid) begin
      case (state)
        IDLE: state_n = bus.rx_data == SYNC_BYTE ? HDR : IDLE;
        HDR: begin
          err_n = bus.rx_data[6:0] == 7'd0;
          state_n = err_n ? IDLE : IDX_HI;
        end
        IDX_HI: state_n = IDX_LO;
        IDX_LO: begin
          err_n = (idx_w >> IDX_W) != 16'd0 || (!first && idx_w <= 16'(prev));
          state_n = err_n ? IDLE : VAL_HI;
        end
        VAL_HI: state_n = VAL_LO;
        VAL_LO: state_n = count == 7'd1 ? CSUM : IDX_HI;
        CSUM: begin
          ok_n = bus.rx_data == csum;
          err_n = !ok_n;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      csum <= '0;
      idx_hi <= '0;
      val_hi <= '0;
      resp <= '0;
      count <= '0;
      cur <= '0;
      prev <= '0;
      tcnt <= '0;
      vec <= 1'b0;
      first <= 1'b0;
      push_q <= 1'b0;
      push_d <= '0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      ok_q <= ok_n;
      err_q <= err_n;
      push_q <= 1'b0;
      tcnt <= (bus.rx_valid || state == IDLE) ? '0 : tcnt + TW'(1);
      if (bus.rx_valid && !drop) begin
        csum <= state == HDR ? bus.rx_data : csum ^ bus.rx_data;
        if (state == HDR) begin
          vec <= bus.rx_data[7];
          count <= bus.rx_data[6:0];
          first <= 1'b1;
        end
        if (state == IDX_HI) idx_hi <= bus.rx_data;
        if (state == IDX_LO) cur <= idx_w[IDX_W-1:0];
        if (state == VAL_HI) val_hi <= bus.rx_data;
        if (state == VAL_LO) begin
          push_q <= 1'b1;
          push_d <= '{vec: vec, index: ENTRY_IDX_W'(cur), value: {val_hi, bus.rx_data}, last: count == 7'd1};
          prev <= cur;
          first <= 1'b0;
          count <= count - 7'd1;
        end
      end
      if (ok_n || err_n || drop) begin
        pend <= 1'b1;
        resp <= ok_n ? ACK_BYTE : NAK_BYTE;
      end else if (pend && !bus.tx_busy) pend <= 1'b0;
    end
  end
  assign bus.entry_valid = !empty;
  assign bus.entry_vec = head.vec;
  assign bus.entry_index = IDX_W'(head.index);
  assign bus.entry_value = head.value;
  assign bus.entry_last = head.last;
  assign bus.frame_ok = ok_q;
  assign bus.frame_error = err_q | drop;
  assign bus.tx_data = resp;
  assign bus.tx_start = pend & !bus.tx_busy;
endmodule

// File: tb/tb_sparse_frame_loader.sv
// tb_sparse_frame_loader: directed and random frames checked every cycle against a positional frame model
module tb_sparse_frame_loader;
  localparam int TMO = 60;
  localparam int DEPTH = 8;
  localparam int IDX_LIM = 1024;
  typedef struct packed {logic v; logic [15:0] i; logic [15:0] d; logic l;} ment_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  sparse_frame_loader_if #(.IDX_W(10)) bus ();
  sparse_frame_loader #(.IDX_W(10), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int checks = 0, failures = 0;
  int rdy_mode, busy_mode;
  int obs_ok = 0, obs_err = 0, n_tx = 0;
  logic [7:0] last_tx = 8'h00;
  ment_t seen[$];
  logic [7:0] fb[$];
  ment_t mq[$];
  logic [7:0] fr[$];
  ment_t pe;
  logic started = 1'b0, inf, pp, ok_m, err_m, pend_m, popm, dropm, ev, bad, good, vm, dropc;
  logic [7:0] resp_m, x;
  logic [15:0] ix, lastix;
  int gap, nm, p, k, j;
  task automatic chk(input string nm_s, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm_s, a, e);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      mq.delete(); fr.delete();
      inf = 0; gap = 0; pp = 0; ok_m = 0; err_m = 0; pend_m = 0; resp_m = 8'h00;
      started = 1'b1;
    end else begin
      popm = bus.entry_ready && mq.size() > 0;
      dropm = pp && mq.size() == DEPTH && !popm;
      ok_m = 0; err_m = 0; ev = 0; bad = 0; good = 0;
      if (popm) void'(mq.pop_front());
      if (pp && !dropm) mq.push_back(pe);
      pp = 0;
      if (dropm) begin
        inf = 0;
        ev = 1;
      end else if (inf && !bus.rx_valid) begin
        gap++;
        if (gap == TMO) bad = 1;
      end else if (bus.rx_valid) begin
        gap = 0;
        if (!inf) begin
          if (bus.rx_data == 8'hA5) begin
            inf = 1;
            fr.delete();
          end
        end else begin
          fr.push_back(bus.rx_data);
          p = fr.size() - 1;
          if (p == 0) begin
            nm = int'(bus.rx_data[6:0]);
            vm = bus.rx_data[7];
            if (nm == 0) bad = 1;
          end else if (p <= 4 * nm) begin
            k = (p - 1) / 4;
            j = (p - 1) % 4;
            if (j == 1) begin
              ix = {fr[p-1], bus.rx_data};
              if (int'(ix) >= IDX_LIM || (k > 0 && ix <= lastix)) bad = 1;
              lastix = ix;
            end
            if (j == 3) begin
              pp = 1;
              pe.v = vm; pe.i = ix; pe.d = {fr[p-1], bus.rx_data}; pe.l = (k == nm - 1);
            end
          end else begin
            x = 8'h00;
            for (int q = 0; q < p; q++) x ^= fr[q];
            if (x == bus.rx_data) good = 1; else bad = 1;
          end
        end
      end
      if (bad) begin err_m = 1; inf = 0; end
      if (good) begin ok_m = 1; inf = 0; end
      if (ev || bad || good) begin
        pend_m = 1;
        resp_m = good ? 8'h06 : 8'h15;
      end else if (pend_m && !bus.tx_busy) pend_m = 0;
    end
  end
  always @(negedge clk) begin
    #4;
    if (started && !reset) begin
      ment_t he, s;
      he = mq.size() > 0 ? mq[0] : '0;
      dropc = pp && mq.size() == DEPTH && !(bus.entry_ready && mq.size() > 0);
      chk("entry_valid", 32'(bus.entry_valid), 32'(mq.size() > 0));
      chk("entry_vec", 32'(bus.entry_vec), 32'(he.v));
      chk("entry_index", 32'(bus.entry_index), 32'(he.i));
      chk("entry_value", 32'(bus.entry_value), 32'(he.d));
      chk("entry_last", 32'(bus.entry_last), 32'(he.l));
      chk("frame_ok", 32'(bus.frame_ok), 32'(ok_m));
      chk("frame_error", 32'(bus.frame_error), 32'(err_m || dropc));
      chk("tx_start", 32'(bus.tx_start), 32'(pend_m && !bus.tx_busy));
      chk("tx_data", 32'(bus.tx_data), 32'(resp_m));
      if (bus.entry_valid && bus.entry_ready) begin
        s.v = bus.entry_vec; s.i = 16'(bus.entry_index); s.d = bus.entry_value; s.l = bus.entry_last;
        seen.push_back(s);
      end
      if (bus.frame_ok) obs_ok++;
      if (bus.frame_error) obs_err++;
      if (bus.tx_start) begin
        n_tx++;
        last_tx = bus.tx_data;
      end
    end
  end
  task automatic tick(input logic v, input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data = b;
    bus.entry_ready = rdy_mode == 2 ? 1'($urandom % 2) : rdy_mode[0];
    bus.tx_busy = busy_mode == 2 ? 1'($urandom % 2) : busy_mode[0];
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask
  task automatic send_q(input int gm, input int stall_at);
    foreach (fb[i]) begin
      if (i == stall_at) idle(TMO + 5);
      tick(1'b1, fb[i]);
      idle($urandom_range(0, gm));
    end
  endtask
  task automatic chk_ent(input string nm_s, input int n, input logic [31:0] vd, input logic [1:0] fl);
    chk({nm_s, "_val"}, {seen[n].i, seen[n].d}, vd);
    chk({nm_s, "_flags"}, 32'({seen[n].v, seen[n].l}), 32'(fl));
  endtask
  initial begin
    int n0, s0, n, idx;
    logic [7:0] cs, junk;
    logic [15:0] iv, vv;
    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.entry_ready = 1'b1; bus.tx_busy = 1'b0;
    rdy_mode = 1; busy_mode = 0;
    idle(3);
    #4;
    chk("rst_entry_valid", 32'(bus.entry_valid), 0);
    chk("rst_frame_error", 32'(bus.frame_error), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    reset = 1'b0;
    fb = '{8'hA5, 8'h02, 8'h00, 8'h03, 8'h3C, 8'h00, 8'h00, 8'h07, 8'h40, 8'h00, 8'h7A};
    send_q(0, -1); idle(6);
    chk("t1_count", seen.size(), 2);
    chk_ent("t1_e0", 0, 32'h0003_3C00, 2'b00);
    chk_ent("t1_e1", 1, 32'h0007_4000, 2'b01);
    chk("t1_ok", obs_ok, 1);
    chk("t1_ack", 32'(last_tx), 32'h06);
    fb[10] = 8'h7B;
    send_q(0, -1); idle(6);
    chk("t2_count", seen.size(), 4);
    chk("t2_err", obs_err, 1);
    chk("t2_nak", 32'(last_tx), 32'h15);
    fb = '{8'hA5, 8'h81, 8'h04, 8'h00, 8'h3C, 8'h00, 8'h00};
    send_q(0, -1); idle(6);
    chk("t3_count", seen.size(), 4);
    chk("t3_err", obs_err, 2);
    fb = '{8'hA5, 8'h81, 8'h03, 8'hFF, 8'h12, 8'h34, 8'h5B};
    send_q(1, -1); idle(6);
    chk_ent("t3_e4", 4, 32'h03FF_1234, 2'b11);
    chk("t3_ok", obs_ok, 2);
    fb = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h11, 8'h11, 8'h00, 8'h02, 8'h22, 8'h22, 8'h00};
    send_q(0, -1); idle(6);
    chk("t4_count", seen.size(), 6);
    chk_ent("t4_e5", 5, 32'h0005_1111, 2'b00);
    chk("t4_err", obs_err, 3);
    rdy_mode = 0;
    fb = '{8'hA5, 8'h09};
    for (int i = 1; i <= 9; i++) fb = {fb, 8'h00, 8'(i), 8'h01, 8'(i)};
    fb.push_back(8'h00);
    send_q(0, -1); idle(4);
    chk("t5_err", obs_err, 4);
    chk("t5_held", 32'(bus.entry_valid), 1);
    rdy_mode = 1;
    idle(12);
    chk("t5_count", seen.size(), 14);
    for (int i = 0; i < 8; i++) chk_ent("t5_drain", 6 + i, {16'(i + 1), 16'h0100 + 16'(i + 1)}, 2'b00);
    busy_mode = 1;
    n0 = n_tx;
    fb = '{8'hA5, 8'h01, 8'h00};
    send_q(0, -1); idle(TMO + 10);
    chk("t6_err", obs_err, 5);
    chk("t6_withheld", n_tx, n0);
    busy_mode = 0;
    idle(3);
    chk("t6_sent", n_tx, n0 + 1);
    chk("t6_nak", 32'(last_tx), 32'h15);
    busy_mode = 1; rdy_mode = 0;
    fb = '{8'hA5, 8'h01, 8'h00, 8'h09, 8'h01, 8'h02, 8'h00};
    send_q(0, -1);
    fb = '{8'hA5, 8'h02, 8'h00, 8'h03, 8'h3C, 8'h00, 8'h00};
    send_q(0, -1); idle(2);
    n0 = n_tx; s0 = seen.size();
    reset = 1'b1;
    idle(2);
    #4;
    chk("t7_entry_valid", 32'(bus.entry_valid), 0);
    chk("t7_entry_index", 32'(bus.entry_index), 0);
    chk("t7_frame_ok", 32'(bus.frame_ok), 0);
    chk("t7_frame_error", 32'(bus.frame_error), 0);
    chk("t7_tx_data", 32'(bus.tx_data), 0);
    reset = 1'b0;
    busy_mode = 0; rdy_mode = 1;
    idle(10);
    chk("t7_no_resp", n_tx, n0);
    chk("t7_no_entry", seen.size(), s0);
    repeat (150) begin
      int kind;
      kind = $urandom % 8;
      n = 1 + $urandom % (kind == 7 ? 11 : 6);
      rdy_mode = $urandom % 3;
      busy_mode = ($urandom % 2) * 2;
      if ($urandom % 4 == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h00;
        tick(1'b1, junk);
      end
      fb = '{8'hA5, {1'($urandom % 2), kind == 4 ? 7'd0 : 7'(n)}};
      cs = fb[1];
      idx = $urandom % 300;
      for (int e = 0; e < n; e++) begin
        if (e > 0) idx += (kind == 2 && e == n - 1) ? 0 : 1 + $urandom % 40;
        iv = (kind == 3 && e == 0) ? 16'h0400 | 16'(idx) : 16'(idx);
        vv = 16'($urandom);
        fb = {fb, iv[15:8], iv[7:0], vv[15:8], vv[7:0]};
        cs ^= iv[15:8] ^ iv[7:0] ^ vv[15:8] ^ vv[7:0];
      end
      fb.push_back(kind == 1 ? cs ^ 8'h01 : cs);
      send_q(2, kind == 5 ? 3 : -1);
      idle($urandom_range(1, 6));
    end
    rdy_mode = 1; busy_mode = 0;
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sparse_frame_loader.md
Name: sparse_frame_loader

Overview:
- Sits directly downstream of the UART comm block in the sparse matrix coprocessor.
- Deframes the received byte stream into sparse-vector entries (index, 16-bit half-float value) and buffers them in a small FIFO.
- The FIFO feeds the PIC index-match/multiply stage.
- Returns a one-byte ACK/NAK per frame through the UART transmit handshake.

Parameters:
- IDX_W, 10, width of entry index; 16-bit wire index must fit.
- FIFO_DEPTH, 8, entry FIFO depth (power of 2, ≥2).
- TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from comm
- rx_valid  in  1  one-cycle strobe, rx_data valid
- entry_valid  out  1  FIFO head valid
- entry_ready  in  1  consumer accepts head when entry_valid&entry_ready
- entry_vec  out  1  0 = vector A, 1 = vector B
- entry_index  out  IDX_W  entry index
- entry_value  out  16  half-float value
- entry_last  out  1  final entry of its frame
- frame_ok  out  1  one-cycle pulse, frame checksum good
- frame_error  out  1  one-cycle pulse, frame rejected
- tx_data  out  8  response byte
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy

Behaviour:
- Frame format: SYNC 0xA5, HDR, then N×{IDX_HI, IDX_LO, VAL_HI, VAL_LO}, then CSUM.
  - HDR[7] = vec; HDR[6:0] = N, with N in 1..127.
  - CSUM = XOR of HDR and all entry bytes.
- Reset: all outputs 0; FIFO emptied; state IDLE; running XOR, last-index, timeout counter and pending response cleared.
  - A reset mid-frame discards the partial frame with no response.
- States: IDLE, HDR, IDX_HI, IDX_LO, VAL_HI, VAL_LO, CSUM. Transitions occur only on rx_valid, except timeout.
  - IDLE: byte 0xA5 → HDR; any other byte is ignored.
  - HDR: N = 0 → error; else latch vec and N, count = N → IDX_HI.
  - IDX_LO: the 16-bit index must have bits [15:IDX_W] zero. It must be strictly greater than the previous index of the same frame; the first entry is exempt. Violation → error.
  - VAL_LO: push {vec, index, value, last = (count == 1)} into the FIFO in the cycle after the byte.
    - If the FIFO is full at push → error, entry dropped.
    - Then decrement count: count = 0 → CSUM, else → IDX_HI.
  - CSUM: match → frame_ok pulse, queue ACK 0x06; mismatch → error. Return to IDLE.
- Error (any state):
  - frame_error pulses for one cycle; queue NAK 0x15; return to IDLE.
  - Entries already pushed from the bad frame stay in the FIFO. The consumer discards them on frame_error.
  - Remaining bytes of the bad frame are hunted through for SYNC.
- Timeout: counter resets on every rx_valid and counts in every non-IDLE state. Reaching TIMEOUT_CYCLES → error.
- Status pulse timing: frame_ok and frame_error pulse in the cycle after the CSUM (or offending) byte. They may precede the FIFO drain.
- FIFO: first-word-fall-through.
  - entry_valid = !empty.
  - A push and a pop in the same cycle while full succeed, with no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Tx: one response register.
  - When a response is pending and tx_busy = 0: drive tx_data and pulse tx_start for one cycle, then clear pending.
  - A new response while one is pending overwrites it (latest wins).
  - tx_start never asserts while tx_busy = 1.
- Byte latency: one byte per rx_valid. Back-to-back rx_valid on consecutive cycles must be handled.

Decomposition:
- Package sparse_pkg holds:
  - SYNC_BYTE, ACK_BYTE, NAK_BYTE constants;
  - the loader_state_t enum;
  - the entry_t packed struct {vec, index, value, last}.
- One sub-module, sparse_entry_fifo: synchronous FWFT FIFO of entry_t, parameterised by FIFO_DEPTH, with full/empty flags.
- The parser FSM, checksum and tx logic live in sparse_frame_loader.

Test Plan:
- Frame A5 02 0003 3C00 0007 4000, CSUM = 0x02^0x03^0x3C^0x07^0x40 = 0x7A, entry_ready = 1 → entries (A,3,0x3C00,last 0), (A,7,0x4000,last 1); frame_ok pulse; tx_data 0x06 with tx_start.
- Same frame with CSUM 0x7B → both entries emitted, frame_error pulse, tx_data 0x15.
- HDR 0x81 with index 0x0400 (IDX_W = 10) → frame_error, NAK, no entry pushed. Then a good frame with vec = 1 → accepted.
- Descending indices 0x0005 then 0x0002 → first entry pushed, second rejected, frame_error.
- entry_ready = 0, frame N = 9 → 8 entries buffered, 9th overflows → frame_error. Then drain 8 entries, each with correct order and values.
- Frame stalled after IDX_HI for TIMEOUT_CYCLES → frame_error and NAK. tx_busy = 1 held → tx_start withheld until tx_busy drops. Reset asserted mid-frame → all outputs 0, no response sent.
